// File: rtl/sprite_pixel_gen.sv
// Sprite pixel generator: one square sprite moved per frame (push buttons or diagonal bounce), coloured per scan position.
// Latency: rgb is registered, 1 cycle after pixel_x/pixel_y/video_on/switch; position updates on the edge where frame_tick is high.
// Backpressure: none; free-running pixel pipeline that accepts a new scan position every clock.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   push[3:0]          [0] right, [1] left, [2] down, [3] up (level, sampled on frame tick)
//   switch             sprite colour
//   mode               0 = MANUAL, 1 = BOUNCE (sampled on frame tick)
//   pixel_x/pixel_y    current scan position from the sync generator
//   video_on           visible-area flag
//   rgb                registered pixel colour
//   frame_tick         one-cycle pulse per frame
//   sprite_x/sprite_y  current sprite top-left position
//
// Build option: define SPRITE_BORDER_EN to draw the sprite's outermost
// 1-pixel ring in ~switch (interior stays switch).

module sprite_pixel_gen #(
    parameter int                 H_ACTIVE  = 640,
    parameter int                 V_ACTIVE  = 480,
    parameter int                 SIZE      = 40,
    parameter int                 VEL       = 5,
    parameter int                 COLOR_W   = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR  = COLOR_W'(3'b110),
    parameter int                 TICK_LINE = 481,
    parameter int                 INIT_X    = 320,
    parameter int                 INIT_Y    = 240
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         push,
    input  logic [COLOR_W-1:0] switch,
    input  logic               mode,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               video_on,
    output logic [COLOR_W-1:0] rgb,
    output logic               frame_tick,
    output logic [9:0]         sprite_x,
    output logic [9:0]         sprite_y
);

    // Position arithmetic is carried in 11 bits so that x+VEL or
    // x+SIZE-1 can never wrap before it is compared with a bound.
    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - SIZE);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - SIZE);
    localparam logic [10:0] STEP   = 11'(VEL);
    localparam logic [10:0] SPAN   = 11'(SIZE - 1);
    localparam logic [9:0]  TICK_Y = 10'(TICK_LINE);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_BOUNCE = 1'b1
    } state_t;

    // dx_pos/dy_pos: 1 = moving right/down, 0 = moving left/up.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx_pos;
        logic       dy_pos;
    } sprite_t;

    localparam sprite_t SPRITE_RST = '{
        x:      10'(INIT_X),
        y:      10'(INIT_Y),
        dx_pos: 1'b1,
        dy_pos: 1'b1
    };

    // ------------------------------------------------------------------
    // Clamped single-axis steps
    // ------------------------------------------------------------------
    function automatic logic [9:0] step_up(input logic [9:0] p, input logic [10:0] lim);
        logic [10:0] sum;
        sum = {1'b0, p} + STEP;
        return (sum >= lim) ? lim[9:0] : sum[9:0];
    endfunction

    function automatic logic [9:0] step_down(input logic [9:0] p);
        logic [10:0] diff;
        diff = {1'b0, p} - STEP;
        return ({1'b0, p} <= STEP) ? 10'd0 : diff[9:0];
    endfunction

    // ------------------------------------------------------------------
    // Frame tick: rising edge of the raw line/column match, so a raw
    // condition held for several clocks still yields a single pulse.
    // ------------------------------------------------------------------
    logic raw;
    logic raw_d;

    assign raw = (pixel_y == TICK_Y) && (pixel_x == 10'd0);

    // ------------------------------------------------------------------
    // Movement state
    // ------------------------------------------------------------------
    state_t  state_q;
    state_t  state_n;
    sprite_t spr_q;
    sprite_t spr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_MANUAL;
            spr_q   <= SPRITE_RST;
        end else begin
            state_q <= state_n;
            spr_q   <= spr_n;
        end
    end

    // The state register is updated on the same tick it is consulted,
    // so a mode change only takes effect from the following tick.
    always_comb begin
        state_n = state_q;
        spr_n   = spr_q;
        if (frame_tick) begin
            state_n = mode ? ST_BOUNCE : ST_MANUAL;
            case (state_q)
                ST_MANUAL: begin
                    if (push[0]) begin
                        spr_n.x = step_up(spr_q.x, XMAX);
                    end else if (push[1]) begin
                        spr_n.x = step_down(spr_q.x);
                    end else if (push[2]) begin
                        spr_n.y = step_up(spr_q.y, YMAX);
                    end else if (push[3]) begin
                        spr_n.y = step_down(spr_q.y);
                    end
                end
                ST_BOUNCE: begin
                    // An axis that lands on a bound (exactly or by
                    // clamping) reverses for the next tick.
                    if (spr_q.dx_pos) begin
                        spr_n.x      = step_up(spr_q.x, XMAX);
                        spr_n.dx_pos = ({1'b0, spr_n.x} != XMAX);
                    end else begin
                        spr_n.x      = step_down(spr_q.x);
                        spr_n.dx_pos = (spr_n.x == 10'd0);
                    end
                    if (spr_q.dy_pos) begin
                        spr_n.y      = step_up(spr_q.y, YMAX);
                        spr_n.dy_pos = ({1'b0, spr_n.y} != YMAX);
                    end else begin
                        spr_n.y      = step_down(spr_q.y);
                        spr_n.dy_pos = (spr_n.y == 10'd0);
                    end
                end
                default: begin
                    state_n = ST_MANUAL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hit test against the current (registered) position, inclusive.
    // ------------------------------------------------------------------
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] x_lo;
    logic [10:0] x_hi;
    logic [10:0] y_lo;
    logic [10:0] y_hi;
    logic        hit;

    assign px   = {1'b0, pixel_x};
    assign py   = {1'b0, pixel_y};
    assign x_lo = {1'b0, spr_q.x};
    assign y_lo = {1'b0, spr_q.y};
    assign x_hi = x_lo + SPAN;
    assign y_hi = y_lo + SPAN;
    assign hit  = (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi);

`ifdef SPRITE_BORDER_EN
    logic on_ring;
    assign on_ring = (px == x_lo) || (px == x_hi) || (py == y_lo) || (py == y_hi);
`endif

    logic [COLOR_W-1:0] rgb_n;

    always_comb begin
        rgb_n = '0;
        if (!video_on) begin
            rgb_n = '0;
        end else if (hit) begin
`ifdef SPRITE_BORDER_EN
            rgb_n = on_ring ? ~switch : switch;
`else
            rgb_n = switch;
`endif
        end else begin
            rgb_n = BG_COLOR;
        end
    end

    // ------------------------------------------------------------------
    // Output / tick registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_d      <= 1'b0;
            frame_tick <= 1'b0;
            rgb        <= '0;
        end else begin
            raw_d      <= raw;
            frame_tick <= raw && !raw_d;
            rgb        <= rgb_n;
        end
    end

    assign sprite_x = spr_q.x;
    assign sprite_y = spr_q.y;

endmodule

// File: tb/tb_sprite_pixel_gen.sv
module tb_sprite_pixel_gen;

    localparam int XMAX = 600;
    localparam int YMAX = 440;
    localparam int SIZE = 40;
    localparam logic [2:0] BG = 3'b110;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] push;
    logic [2:0] switch;
    logic       mode;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;

    logic [2:0] rgb, rgb7;
    logic       frame_tick, frame_tick7;
    logic [9:0] sprite_x, sprite_y, sprite_x7, sprite_y7;

    int checks = 0;
    int failures = 0;

    // Reference model: [0] default build (VEL=5), [1] VEL=7 instance.
    int mx[2], my[2], mdx[2], mdy[2], vel[2];
    logic mb[2];

    always #5 clk = ~clk;

    sprite_pixel_gen dut (
        .clk(clk), .rst(rst), .push(push), .switch(switch), .mode(mode),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .rgb(rgb), .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y)
    );

    sprite_pixel_gen #(.VEL(7)) dut7 (
        .clk(clk), .rst(rst), .push(push), .switch(switch), .mode(mode),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .rgb(rgb7), .frame_tick(frame_tick7), .sprite_x(sprite_x7), .sprite_y(sprite_y7)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        vel[0] = 5;
        vel[1] = 7;
        for (int i = 0; i < 2; i++) begin
            mx[i] = 320; my[i] = 240; mdx[i] = 1; mdy[i] = 1; mb[i] = 1'b0;
        end
    endtask

    // One frame of movement, computed from the rules with plain integers.
    task automatic model_tick(input logic [3:0] p, input logic md);
        for (int i = 0; i < 2; i++) begin
            if (mb[i]) begin
                mx[i] = mx[i] + mdx[i] * vel[i];
                my[i] = my[i] + mdy[i] * vel[i];
                if (mx[i] >= XMAX) begin mx[i] = XMAX; mdx[i] = -1; end
                else if (mx[i] <= 0) begin mx[i] = 0; mdx[i] = 1; end
                if (my[i] >= YMAX) begin my[i] = YMAX; mdy[i] = -1; end
                else if (my[i] <= 0) begin my[i] = 0; mdy[i] = 1; end
            end else if (p[0]) mx[i] = (mx[i] + vel[i] > XMAX) ? XMAX : mx[i] + vel[i];
            else if (p[1])     mx[i] = (mx[i] - vel[i] < 0) ? 0 : mx[i] - vel[i];
            else if (p[2])     my[i] = (my[i] + vel[i] > YMAX) ? YMAX : my[i] + vel[i];
            else if (p[3])     my[i] = (my[i] - vel[i] < 0) ? 0 : my[i] - vel[i];
            mb[i] = md;
        end
    endtask

    function automatic logic [2:0] exp_rgb(input int px, input int py, input logic von,
                                           input logic [2:0] sw);
        bit inside_spr, ring;
        if (!von) return 3'b000;
        inside_spr = px >= mx[0] && px < mx[0] + SIZE && py >= my[0] && py < my[0] + SIZE;
        if (!inside_spr) return BG;
        ring = px == mx[0] || px == mx[0] + SIZE - 1 || py == my[0] || py == my[0] + SIZE - 1;
`ifdef SPRITE_BORDER_EN
        return ring ? ~sw : sw;
`else
        return (ring || !ring) ? sw : ~sw;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; push = 4'b0; mode = 1'b0; video_on = 1'b0;
        pixel_x = 10'd0; pixel_y = 10'd0;
        step();
        rst = 1'b0;
        step();
        model_reset();
    endtask

    // Holds the raw tick condition for 'hold' clocks, then counts pulses.
    task automatic do_tick(input int hold, output int pulses, output int pulses7);
        pulses = 0; pulses7 = 0;
        pixel_y = 10'd481; pixel_x = 10'd0; video_on = 1'b0;
        repeat (hold) begin
            step();
            pulses += int'(frame_tick); pulses7 += int'(frame_tick7);
        end
        pixel_y = 10'd0; pixel_x = 10'd5;
        repeat (2) begin
            step();
            pulses += int'(frame_tick); pulses7 += int'(frame_tick7);
        end
        model_tick(push, mode);
    endtask

    task automatic test_reset();
        push = 4'b0; switch = 3'b0; mode = 1'b0; video_on = 1'b0;
        pixel_x = 10'd0; pixel_y = 10'd0; rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (sprite_x !== 10'd320) begin failures++; $display("FAIL reset_x: got %0d want 320", sprite_x); end
        checks++; if (sprite_y !== 10'd240) begin failures++; $display("FAIL reset_y: got %0d want 240", sprite_y); end
        checks++; if (rgb !== 3'b000) begin failures++; $display("FAIL reset_rgb: got %0d want 0", rgb); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %0d want 0", frame_tick); end
        step();
        rst = 1'b0;
        step();
        model_reset();
    endtask

    task automatic test_tick();
        int p, p7;
        do_reset();
        push = 4'b0001;
        do_tick(4, p, p7);
        checks++; if (p !== 1) begin failures++; $display("FAIL tick_pulses: got %0d want 1", p); end
        checks++; if (p7 !== 1) begin failures++; $display("FAIL tick_pulses7: got %0d want 1", p7); end
        checks++; if (sprite_x !== 10'd325) begin failures++; $display("FAIL tick_x: got %0d want 325", sprite_x); end
        checks++; if (sprite_x7 !== mx[1]) begin failures++; $display("FAIL tick_x7: got %0d want %0d", sprite_x7, mx[1]); end
    endtask

    task automatic test_clamp();
        int p, p7;
        do_reset();
        push = 4'b1000;
        for (int t = 1; t <= 37; t++) begin
            do_tick(1 + $urandom_range(0, 3), p, p7);
            checks++; if (sprite_y7 !== my[1]) begin failures++; $display("FAIL clamp_y7 t=%0d: got %0d want %0d", t, sprite_y7, my[1]); end
            checks++; if (sprite_y !== my[0]) begin failures++; $display("FAIL clamp_y t=%0d: got %0d want %0d", t, sprite_y, my[0]); end
            if (t == 34) begin
                checks++; if (sprite_y7 !== 10'd2) begin failures++; $display("FAIL clamp_34: got %0d want 2", sprite_y7); end
            end
            if (t >= 35) begin
                checks++; if (sprite_y7 !== 10'd0) begin failures++; $display("FAIL clamp_floor t=%0d: got %0d want 0", t, sprite_y7); end
            end
        end
    endtask

    task automatic test_priority();
        int p, p7;
        do_reset();
        push = 4'b1111;
        for (int t = 1; t <= 60; t++) begin
            do_tick(1, p, p7);
            checks++; if (sprite_x !== mx[0]) begin failures++; $display("FAIL prio_x t=%0d: got %0d want %0d", t, sprite_x, mx[0]); end
            checks++; if (sprite_y !== 10'd240) begin failures++; $display("FAIL prio_y t=%0d: got %0d want 240", t, sprite_y); end
            if (t >= 56) begin
                checks++; if (sprite_x !== 10'd600) begin failures++; $display("FAIL prio_hold t=%0d: got %0d want 600", t, sprite_x); end
            end
        end
    endtask

    task automatic test_bounce();
        int p, p7;
        do_reset();
        mode = 1'b1; push = 4'b0;
        do_tick(2, p, p7);
        checks++; if (sprite_x !== 10'd320 || sprite_y !== 10'd240) begin failures++; $display("FAIL bounce_arm: got (%0d,%0d) want (320,240)", sprite_x, sprite_y); end
        for (int t = 1; t <= 60; t++) begin
            push = 4'($urandom);
            do_tick(1, p, p7);
            checks++; if (sprite_x !== mx[0] || sprite_y !== my[0]) begin failures++; $display("FAIL bounce_pos t=%0d: got (%0d,%0d) want (%0d,%0d)", t, sprite_x, sprite_y, mx[0], my[0]); end
            checks++; if (sprite_x7 !== mx[1] || sprite_y7 !== my[1]) begin failures++; $display("FAIL bounce_pos7 t=%0d: got (%0d,%0d) want (%0d,%0d)", t, sprite_x7, sprite_y7, mx[1], my[1]); end
            if (t == 40) begin checks++; if (sprite_y !== 10'd440) begin failures++; $display("FAIL bounce_y40: got %0d want 440", sprite_y); end end
            if (t == 41) begin checks++; if (sprite_y !== 10'd435) begin failures++; $display("FAIL bounce_y41: got %0d want 435", sprite_y); end end
            if (t == 56) begin checks++; if (sprite_x !== 10'd600) begin failures++; $display("FAIL bounce_x56: got %0d want 600", sprite_x); end end
            if (t == 57) begin checks++; if (sprite_x !== 10'd595) begin failures++; $display("FAIL bounce_x57: got %0d want 595", sprite_x); end end
        end
    endtask

    task automatic test_pixel();
        int pxs[5] = '{320, 359, 360, 330, 340};
        int pys[5] = '{240, 250, 250, 250, 260};
        logic vons[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] want, sw;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sw = 3'($urandom);
            switch = sw; pixel_x = 10'(pxs[i]); pixel_y = 10'(pys[i]); video_on = vons[i];
            want = exp_rgb(pxs[i], pys[i], vons[i], sw);
            step();
            checks++; if (rgb !== want) begin failures++; $display("FAIL pixel_%0d: got %0d want %0d", i, rgb, want); end
            checks++; if (rgb7 !== want) begin failures++; $display("FAIL pixel7_%0d: got %0d want %0d", i, rgb7, want); end
            if (i == 2) begin
                checks++; if (rgb !== BG) begin failures++; $display("FAIL pixel_bg: got %0d want %0d", rgb, BG); end
            end
            // Output must not follow the new input until the next edge.
            pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0;
            #1;
            checks++; if (rgb !== want) begin failures++; $display("FAIL pixel_latency_%0d: got %0d want %0d", i, rgb, want); end
        end
    endtask

    task automatic test_midframe_push();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push = 4'($urandom); mode = 1'($urandom);
            pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 479));
            step();
        end
        checks++; if (sprite_x !== 10'd320 || sprite_y !== 10'd240) begin failures++; $display("FAIL midframe_hold: got (%0d,%0d) want (320,240)", sprite_x, sprite_y); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL midframe_tick: got %0d want 0", frame_tick); end
    endtask

    task automatic test_reset_mid();
        int p, p7;
        do_reset();
        push = 4'b0100;
        do_tick(1, p, p7);
        pixel_x = 10'd100; pixel_y = 10'd100; video_on = 1'b1;
        step();
        pixel_y = 10'd481; pixel_x = 10'd0; video_on = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++; if (sprite_x !== 10'd320 || sprite_y !== 10'd240) begin failures++; $display("FAIL rstmid_pos: got (%0d,%0d) want (320,240)", sprite_x, sprite_y); end
        checks++; if (frame_tick !== 1'b0 || rgb !== 3'b000) begin failures++; $display("FAIL rstmid_out: got tick=%0d rgb=%0d want 0,0", frame_tick, rgb); end
        pixel_y = 10'd0; pixel_x = 10'd5;
        step();
        rst = 1'b0;
        step();
        model_reset();
        push = 4'b0001;
        do_tick(3, p, p7);
        checks++; if (p !== 1) begin failures++; $display("FAIL rstmid_pulses: got %0d want 1", p); end
        checks++; if (sprite_x !== mx[0] || sprite_y !== my[0]) begin failures++; $display("FAIL rstmid_after: got (%0d,%0d) want (%0d,%0d)", sprite_x, sprite_y, mx[0], my[0]); end
    endtask

    task automatic test_random();
        int p, p7, px, py;
        logic von;
        logic [2:0] sw, want;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            push = 4'($urandom);
            mode = ($urandom_range(0, 3) == 0);
            do_tick(1 + $urandom_range(0, 2), p, p7);
            checks++; if (p !== 1) begin failures++; $display("FAIL rand_pulses t=%0d: got %0d want 1", t, p); end
            checks++; if (sprite_x !== mx[0] || sprite_y !== my[0]) begin failures++; $display("FAIL rand_pos t=%0d: got (%0d,%0d) want (%0d,%0d)", t, sprite_x, sprite_y, mx[0], my[0]); end
            checks++; if (sprite_x7 !== mx[1] || sprite_y7 !== my[1]) begin failures++; $display("FAIL rand_pos7 t=%0d: got (%0d,%0d) want (%0d,%0d)", t, sprite_x7, sprite_y7, mx[1], my[1]); end
            for (int k = 0; k < 6; k++) begin
                px = mx[0] + $urandom_range(0, SIZE + 5) - 3;
                py = my[0] + $urandom_range(0, SIZE + 5) - 3;
                px = (px < 0) ? 0 : (px > 639) ? 639 : px;
                py = (py < 0) ? 0 : (py > 479) ? 479 : py;
                von = ($urandom_range(0, 4) != 0);
                sw = 3'($urandom);
                push = 4'($urandom);
                pixel_x = 10'(px); pixel_y = 10'(py); video_on = von; switch = sw;
                want = exp_rgb(px, py, von, sw);
                step();
                checks++; if (rgb !== want) begin failures++; $display("FAIL rand_rgb t=%0d (%0d,%0d): got %0d want %0d", t, px, py, rgb, want); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_clamp();
        test_priority();
        test_bounce();
        test_pixel();
        test_midframe_push();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_gen.md
# sprite_pixel_gen

Parametrised sprite pixel generator for the VGA display path. Holds one square sprite whose position updates once per frame. In MANUAL mode the push buttons move it; in BOUNCE mode it moves diagonally and reflects off the screen edges. Each cycle it produces a registered colour for the current scan position. It sits between the VGA sync generator (pixel_x, pixel_y, video_on) and the DAC/pin driver.

## Interface
Parameters:
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- SIZE, 40, sprite edge length in pixels (1..V_ACTIVE)
- VEL, 5, pixels moved per frame tick (1..SIZE)
- COLOR_W, 3, colour width
- BG_COLOR, 3'b110, background colour (COLOR_W bits)
- TICK_LINE, 481, pixel_y value that marks the frame tick
- INIT_X, 320 / INIT_Y, 240, sprite top-left after reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- push  in  4  [0] right, [1] left, [2] down, [3] up; level-sensitive
- switch  in  COLOR_W  sprite colour
- mode  in  1  0 = MANUAL, 1 = BOUNCE
- pixel_x, pixel_y  in  10  current scan position
- video_on  in  1  visible-area flag
- rgb  out  COLOR_W  registered pixel colour
- frame_tick  out  1  one-cycle pulse per frame
- sprite_x, sprite_y  out  10  current top-left position

## Operation
- Tick: raw = (pixel_y == TICK_LINE && pixel_x == 0). frame_tick = raw && !raw_d, where raw_d is raw registered. The result is exactly one pulse per frame, however many clocks the raw condition lasts.
- Mode state register: MANUAL or BOUNCE. It samples mode only on frame_tick. The new state governs movement starting from the next tick. Resets to MANUAL.
- Position arithmetic uses 11 bits and never wraps.
  - Legal x range: 0 .. XMAX = H_ACTIVE-SIZE.
  - Legal y range: 0 .. YMAX = V_ACTIVE-SIZE.
  - Any step that would leave the range clamps to the bound.
- MANUAL, on frame_tick: priority is push[0] > push[1] > push[2] > push[3]. One axis moves by VEL per tick. With no push, the position holds.
- BOUNCE, on frame_tick: both axes step by VEL in direction dx, dy. An axis that reaches or clamps to a bound lands exactly on that bound and inverts its direction for the following tick. dx and dy reset to + (right, down) and keep their values while in MANUAL.
- Hit test (inclusive): sprite_x <= pixel_x <= sprite_x+SIZE-1 and sprite_y <= pixel_y <= sprite_y+SIZE-1.
- Colour selection:
  - video_on = 0: 0
  - hit: switch
  - otherwise: BG_COLOR

## Timing
- Reset values:
  - sprite_x = INIT_X, sprite_y = INIT_Y
  - rgb = 0, frame_tick = 0
  - raw_d = 0, state = MANUAL, dx = +, dy = +
- rgb latency: 1 cycle. rgb at edge N+1 reflects pixel_x, pixel_y, video_on, switch and position as of edge N.
- frame_tick rises 1 cycle after raw first becomes true. Position updates on the same clock edge that frame_tick is high, so it is visible the cycle after the pulse.
- Position registers change only when frame_tick = 1. A push change mid-frame has no effect until the next tick.
- Reset asserted mid-frame forces all reset values immediately. The first tick after release behaves normally.
- A mode change and pushes in the same tick: the old state decides that tick's movement.

## Configuration
- SPRITE_BORDER_EN defined: hit pixels on the sprite's outermost 1-pixel ring output ~switch. Interior hit pixels output switch.
- SPRITE_BORDER_EN undefined: every hit pixel outputs switch.
- Movement and timing are identical in both builds.

## Test plan
- Reset: assert rst with no clock edge -> sprite_x = 320, sprite_y = 240, rgb = 0, frame_tick = 0 immediately.
- Tick: hold pixel_y = 481, pixel_x = 0 for 4 clocks with push[0] = 1 -> exactly one frame_tick pulse, sprite_x = 325.
- Clamp: VEL = 7, push[3] held -> y steps 240, 233, … down to 2 after 34 ticks. Tick 35 gives y = 0, and y stays 0 on further ticks.
- Priority: push = 4'b1111 -> x increases by 5 per tick, y unchanged. At x = 600, further ticks hold x = 600.
- Bounce: mode = 1 sampled, start (320, 240) -> tick 40 gives y = 440 with dy inverted, tick 41 gives y = 435. x reaches 600 at tick 56, then decreases to 595.
- Pixel/latency: position (320, 240), drive pixel (320, 240) with video_on = 1 -> rgb = switch one cycle later. Ring pixel (359, 250) gives ~switch with SPRITE_BORDER_EN defined. Pixel (360, 250) gives BG_COLOR. video_on = 0 gives 0.
